input_debouncer: RTL and testbench

Conditioning stage placed directly upstream of `edge_detector`: it takes a raw, asynchronous, possibly bouncing level (push-button, external strobe), synchronizes it into the `clk` domain, and releases a level change only after it has been stable for a programmable number of cycles. Its `clean_out` drives `edge_detector.signal_in`, so every rising/falling pulse downstream corresponds to exactly one accepted, bounce-free transition. A saturating counter of rejected glitches is exposed for debug.

---
 rtl/debounce_pkg.sv | 8 +
 rtl/sync_chain.sv | 17 +
 rtl/input_debouncer.sv | 75 +++++++
 tb/tb_input_debouncer.sv | 111 +++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encodings and limits for the input debouncer
package debounce_pkg;
  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] CHECK_HIGH  = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] CHECK_LOW   = 2'd3;
  localparam logic [7:0] GLITCH_MAX  = 8'd255;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer bringing an asynchronous level into the clk domain
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the raw level through the chain; only the last flop is safe to use
  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a bouncing level and releases changes only after they hold stable
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noisy_in,
  output logic       clean_out,
  output logic       busy,
  output logic [7:0] glitch_count
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  logic          sync;
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          abort;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (noisy_in),
    .q    (sync)
  );
  // qualify candidate transitions: a candidate starts counting at 1 and is accepted at CNT_MAX
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    abort   = 1'b0;
    case (state)
      STABLE_LOW: if (sync) begin
        state_n = CHECK_HIGH;
        cnt_n   = CW'(1);
      end
      CHECK_HIGH: if (!sync) begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
        abort   = 1'b1;
      end else if (cnt == CNT_MAX) begin
        state_n = STABLE_HIGH;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      STABLE_HIGH: if (!sync) begin
        state_n = CHECK_LOW;
        cnt_n   = CW'(1);
      end
      default: if (sync) begin
        state_n = STABLE_HIGH;
        cnt_n   = '0;
        abort   = 1'b1;
      end else if (cnt == CNT_MAX) begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
    endcase
  end
  // register state and outputs; encoding gives clean level in bit 1 and checking flag in bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= STABLE_LOW;
      cnt          <= '0;
      clean_out    <= 1'b0;
      busy         <= 1'b0;
      glitch_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      clean_out <= state_n[1];
      busy      <= state_n[0];
      if (abort && glitch_count != GLITCH_MAX) glitch_count <= glitch_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench checking debounce latency, glitch rejection, saturation and reset
module tb_input_debouncer;
  logic       clk = 1'b0;
  logic       reset;
  logic       noisy_in;
  logic       clean_out;
  logic       busy;
  logic [7:0] glitch_count;
  typedef struct {
    int    cyc;
    string tag;
    int    clean;
    int    busy;
    int    glitch;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .noisy_in    (noisy_in),
    .clean_out   (clean_out),
    .busy        (busy),
    .glitch_count(glitch_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  task automatic push(input int k, input string tag, input int c, input int b, input int g);
    exp_t e;
    e.cyc = cyc + k;
    e.tag = tag;
    e.clean = c;
    e.busy = b;
    e.glitch = g;
    q.push_back(e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      if (q[0].cyc < cyc) chk({q[0].tag, "_late"}, cyc, q[0].cyc);
      else begin
        chk({q[0].tag, "_clean"}, int'(clean_out), q[0].clean);
        chk({q[0].tag, "_busy"}, int'(busy), q[0].busy);
        chk({q[0].tag, "_glitch"}, int'(glitch_count), q[0].glitch);
      end
      void'(q.pop_front());
    end
  end
  initial begin
    int g;
    reset = 1'b1;
    noisy_in = 1'b0;
    tick(1);
    for (int k = 1; k <= 2; k++) push(k, "reset", 0, 0, 0);
    tick(2);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) push(k, "idle", 0, 0, 0);
    tick(3);
    noisy_in = 1'b1;
    for (int k = 1; k <= 8; k++) push(k, "rise", k >= 6, k >= 3 && k <= 5, 0);
    tick(8);
    noisy_in = 1'b0;
    for (int k = 1; k <= 8; k++) push(k, "dip2", 1, k >= 3 && k <= 4, k >= 5);
    tick(2);
    noisy_in = 1'b1;
    tick(6);
    noisy_in = 1'b0;
    for (int k = 1; k <= 9; k++) push(k, "dip3", 1, k >= 3 && k <= 5, k >= 6 ? 2 : 1);
    tick(3);
    noisy_in = 1'b1;
    tick(6);
    noisy_in = 1'b0;
    for (int k = 1; k <= 8; k++) push(k, "fall", k < 6, k >= 3 && k <= 5, 2);
    tick(8);
    g = 2;
    for (int i = 0; i < 300; i++) begin
      noisy_in = 1'b1;
      push(3, "sat_busy", 0, 1, g);
      g = (g < 255) ? g + 1 : 255;
      push(6, "sat", 0, 0, g);
      tick(2);
      noisy_in = 1'b0;
      tick(4);
    end
    noisy_in = 1'b1;
    for (int k = 1; k <= 4; k++) push(k, "prerst", 0, k >= 3, 255);
    tick(4);
    reset = 1'b1;
    push(1, "midrst", 0, 0, 0);
    tick(1);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) push(k, "postrst", k >= 6, k >= 3 && k <= 5, 0);
    tick(8);
    tick(2);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
